// File: rtl/bp_packet_serializer.sv
// BytePipe packet serializer: one structured packet in, command/address/data bytes out, LSB first.
module bp_packet_serializer #(
    parameter int unsigned ADDR_BYTES = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [3:0]  i_repOnly_nBytes,
    input  logic        i_repNotReq,
    input  logic [63:0] i_data,
    input  logic [63:0] i_addr,
    input  logic        i_req_readNotWrite,
    input  logic        i_req_incrAddr,
    input  logic        i_req_prevAddr,
    input  logic [3:0]  i_req_nBytes,
    input  logic [1:0]  i_rep_resp,
    input  logic        i_rep_panic,
    input  logic [3:0]  i_rep_hint,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [7:0]  o_data,
    output logic        o_last,
    output logic        o_error
);

    localparam logic [2:0] ADDR_LAST = 3'(ADDR_BYTES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DATA} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [63:0] addr_q, data_q;
    logic        has_addr_q, has_addr_d;
    logic        has_data_q, has_data_d;
    logic [2:0]  data_last_q, data_last_d;
    logic [2:0]  cnt_q;
    logic        error_q;

    logic        accept;
    logic        pkt_ok;
    logic        byte_hs;
    logic [3:0]  nbytes;
    logic [1:0]  req_log2;

    // Decode the offered packet into command byte and sequencing flags
    always_comb begin
        nbytes      = i_repNotReq ? i_repOnly_nBytes : i_req_nBytes;
        pkt_ok      = (i_repNotReq && i_rep_panic) ||
                      (nbytes == 4'd1) || (nbytes == 4'd2) ||
                      (nbytes == 4'd4) || (nbytes == 4'd8);
        case (i_req_nBytes)
            4'd2:    req_log2 = 2'd1;
            4'd4:    req_log2 = 2'd2;
            4'd8:    req_log2 = 2'd3;
            default: req_log2 = 2'd0;
        endcase
        if (i_repNotReq) begin
            cmd_d = {1'b1, i_rep_resp, i_rep_panic, i_rep_hint};
        end else begin
            cmd_d = {1'b0, i_req_readNotWrite, i_req_incrAddr, i_req_prevAddr, 2'b00, req_log2};
        end
        has_addr_d  = !i_repNotReq && !i_req_prevAddr;
        has_data_d  = i_repNotReq ? !i_rep_panic : !i_req_readNotWrite;
        data_last_d = 3'(nbytes - 4'd1);
    end

    // Capture packet fields only on a valid accept so idle-time garbage never enters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cmd_q       <= 8'd0;
            addr_q      <= 64'd0;
            data_q      <= 64'd0;
            has_addr_q  <= 1'b0;
            has_data_q  <= 1'b0;
            data_last_q <= 3'd0;
            error_q     <= 1'b0;
        end else begin
            error_q <= accept && !pkt_ok;
            if (accept && pkt_ok) begin
                cmd_q       <= cmd_d;
                addr_q      <= i_addr;
                data_q      <= i_data;
                has_addr_q  <= has_addr_d;
                has_data_q  <= has_data_d;
                data_last_q <= data_last_d;
            end
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Byte counter: cleared on every state change, advanced per byte handshake
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= 3'd0;
        end else if (state_d != state_q) begin
            cnt_q <= 3'd0;
        end else if (byte_hs) begin
            cnt_q <= cnt_q + 3'd1;
        end
    end

    // Next-state: advance only on byte handshakes so stalls hold everything
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && pkt_ok) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (byte_hs) begin
                    if (has_addr_q)      state_d = ST_ADDR;
                    else if (has_data_q) state_d = ST_DATA;
                    else                 state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (byte_hs && (cnt_q == ADDR_LAST)) begin
                    state_d = has_data_q ? ST_DATA : ST_IDLE;
                end
            end
            ST_DATA: begin
                if (byte_hs && (cnt_q == data_last_q)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        o_ready = (state_q == ST_IDLE) && !i_rst;
        o_valid = 1'b0;
        o_data  = 8'd0;
        o_last  = 1'b0;
        o_error = error_q;
        case (state_q)
            ST_CMD: begin
                o_valid = 1'b1;
                o_data  = cmd_q;
                o_last  = !has_addr_q && !has_data_q;
            end
            ST_ADDR: begin
                o_valid = 1'b1;
                o_data  = addr_q[{cnt_q, 3'b000} +: 8];
                o_last  = (cnt_q == ADDR_LAST) && !has_data_q;
            end
            ST_DATA: begin
                o_valid = 1'b1;
                o_data  = data_q[{cnt_q, 3'b000} +: 8];
                o_last  = (cnt_q == data_last_q);
            end
            default: ;
        endcase
    end

    assign accept  = i_valid && o_ready;
    assign byte_hs = o_valid && i_ready;

endmodule

// File: doc/bp_packet_serializer.md
Name: bp_packet_serializer

Overview:
Converts one structured BytePipe packet per handshake into the BytePipe byte stream consumed by bpAxiMaster. It sits between the packet driver and the bpAxiMaster byte input. Each packet emits one command byte, optional address bytes, and optional data bytes, least significant byte first. Accepted packets with invalid fields are dropped and flagged.

Parameters:
ADDR_BYTES, 8, number of address bytes emitted (1..8); i_addr[8*ADDR_BYTES-1:0] is used and upper bytes are ignored.

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_valid  input  1  packet valid
o_ready  output  1  packet ready; packet accepted when i_valid && o_ready
i_repOnly_nBytes  input  4  reply data byte count: 1, 2, 4 or 8
i_repNotReq  input  1  1 = reply packet, 0 = request packet
i_data  input  64  data, LSB first on the wire
i_addr  input  64  address, LSB first on the wire
i_req_readNotWrite  input  1  request: 1 = read
i_req_incrAddr  input  1  request: increment-address flag
i_req_prevAddr  input  1  request: reuse previous address, so no address bytes are sent
i_req_nBytes  input  4  request byte count: 1, 2, 4 or 8
i_rep_resp  input  2  reply response code
i_rep_panic  input  1  reply panic flag
i_rep_hint  input  4  reply hint
o_valid  output  1  byte valid
i_ready  input  1  byte ready; byte accepted when o_valid && i_ready
o_data  output  8  byte
o_last  output  1  high with the final byte of a packet
o_error  output  1  one-cycle pulse when an accepted packet is dropped

Behaviour:
- Reset (synchronous):
  - state=IDLE, o_valid=0, o_last=0, o_error=0, o_data=0.
  - o_ready=0 while i_rst=1; o_ready=1 in the first cycle after i_rst falls.
- States: IDLE, CMD, ADDR, DATA. o_ready = (state==IDLE) && !i_rst. No packet overlap: at least one idle cycle between packets.
- Accept in IDLE:
  - All inputs are registered.
  - Next state is CMD, or IDLE with o_error=1 for one cycle if the packet is invalid.
  - Invalid means the relevant nBytes is not in {1,2,4,8}: i_req_nBytes for a request, i_repOnly_nBytes for a non-panic reply.
- Latency: accept at cycle N gives the command byte on o_data with o_valid=1 at N+1.
- Command byte for a request: [7]=0, [6]=readNotWrite, [5]=incrAddr, [4]=prevAddr, [3:2]=0, [1:0]=log2(nBytes).
- Command byte for a reply: [7]=1, [6:5]=resp, [4]=panic, [3:0]=hint.
- Sequence after CMD:
  - Request: ADDR (ADDR_BYTES bytes) if !prevAddr, then DATA (nBytes bytes) if !readNotWrite, else done.
  - Reply: DATA (repOnly_nBytes bytes) if !panic, else done.
  - Panic reply: command byte only, and repOnly_nBytes is ignored (never an error).
- Read request with prevAddr=1 is a single byte.
- Byte counter is 3 bits. It clears on each state entry and advances only on a byte handshake. In ADDR and DATA, o_data = register byte[counter].
- Stall: while o_valid && !i_ready, o_data, o_last and state are held stable; o_valid never drops without a handshake.
- o_last is asserted with the final byte. A handshake on the last byte leads to IDLE on the next cycle, with o_valid=0 and o_ready=1.
- Reset mid-packet: the packet is discarded with no further bytes. Next cycle o_valid=0, and state is IDLE after i_rst is released.
- i_ready may be high while o_valid=0 (no effect). Input fields are don't-care when not accepted, and X values on them must not propagate.

Test Plan:
- Reset, then a panic reply (resp=3, panic=1, hint=0xF) -> single byte 0xFF with o_last=1; o_ready=1 two cycles after accept.
- Write request, nBytes=4, incrAddr=1, prevAddr=0, addr=0x0123456789ABCDEF, data=0x00000000DEADBEEF, i_ready always 1 -> 13 bytes: 0x22, EF CD AB 89 67 45 23 01, EF BE AD DE; o_last only on 0xDE.
- Read request, nBytes=8, prevAddr=1 -> single byte 0x53 with o_last=1; no address or data bytes.
- Reply resp=1, panic=0, hint=2, repOnly_nBytes=2, data=0xA55A, with i_ready toggled randomly -> bytes 0xA2, 0x5A, 0xA5; o_data stable during every stall; no byte lost or duplicated.
- Write request with nBytes=3 -> accepted, o_error pulses for one cycle, no o_valid, o_ready returns to 1 next cycle.
- i_rst asserted after the 3rd byte of a 13-byte write -> o_valid=0 next cycle; the next packet starts cleanly with its command byte.
